// File: rtl/stream_demux_pkg.sv
// rtl/stream_demux_pkg.sv - shared slot-state encoding and counter constants
// Purpose: common definitions for stream_demux and stream_demux_slot.
// Contents: slot_state_e (SLOT_EMPTY/SLOT_FULL), COUNT_W, COUNT_MAX.
package stream_demux_pkg;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  localparam int                 COUNT_W   = 16;
  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

endpackage

// File: rtl/stream_demux_slot.sv
// rtl/stream_demux_slot.sv - single-entry holding register for one demux port
// Purpose: holds one beat for a consumer; a load and a drain in the same cycle
//          keep the slot FULL with the new data (no bubble).
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   load, load_data     write a beat into the slot (caller guarantees space)
//   out_valid, out_data held beat towards the consumer
//   out_ready           consumer accepts the held beat
//   out_count           saturating transfer counter (STREAM_DEMUX_STATS_EN only)
module stream_demux_slot
  import stream_demux_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
`ifdef STREAM_DEMUX_STATS_EN
  ,
  output logic [COUNT_W-1:0] out_count
`endif
);

  slot_state_e       state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              drain;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    drain   = (state_q == SLOT_FULL) && out_ready;
    if (load) begin
      state_d = SLOT_FULL;
      data_d  = load_data;
    end else if (drain) begin
      state_d = SLOT_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SLOT_EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = (state_q == SLOT_FULL);
  assign out_data  = data_q;

`ifdef STREAM_DEMUX_STATS_EN
  logic [COUNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (drain && (count_q != COUNT_MAX)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign out_count = count_q;
`endif

endmodule

// File: rtl/stream_demux.sv
// rtl/stream_demux.sv - registered 1-to-N stream demultiplexer
// Purpose: routes each input beat to the port named by Select_Line through a
//          per-port single-entry slot; out-of-range selects are accepted and
//          dropped with a one-cycle Drop_Pulse.
// Ports:
//   Clk, Reset_n                     clock, asynchronous active-low reset
//   In_Data, Select_Line, In_Valid   input beat and its destination
//   In_Ready                         combinational, depends on selected port only
//   Out_Data, Out_Valid, Out_Ready   per-port streams, port k at [k*DATA_W +: DATA_W]
//   Drop_Pulse                       registered drop indication
//   Out_Count                        per-port 16-bit counters (STREAM_DEMUX_STATS_EN only)
// Optional feature macro: STREAM_DEMUX_STATS_EN
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int NUM_OUTPUTS = 4,
  parameter int SEL_W       = 2
) (
  input  logic                          Clk,
  input  logic                          Reset_n,
  input  logic [DATA_W-1:0]             In_Data,
  input  logic [SEL_W-1:0]              Select_Line,
  input  logic                          In_Valid,
  output logic                          In_Ready,
  output logic [NUM_OUTPUTS*DATA_W-1:0] Out_Data,
  output logic [NUM_OUTPUTS-1:0]        Out_Valid,
  input  logic [NUM_OUTPUTS-1:0]        Out_Ready,
  output logic                          Drop_Pulse
`ifdef STREAM_DEMUX_STATS_EN
  ,
  output logic [NUM_OUTPUTS*COUNT_W-1:0] Out_Count
`endif
);

  logic [NUM_OUTPUTS-1:0] sel_hit;
  logic [NUM_OUTPUTS-1:0] load;
  logic                   in_range;
  logic                   accept;
  logic                   drop_q, drop_d;

  // Decode the select as a one-hot vector so that an out-of-range value never
  // indexes Out_Valid/Out_Ready; it simply matches no port.
  always_comb begin
    sel_hit = '0;
    for (int k = 0; k < NUM_OUTPUTS; k++) begin
      sel_hit[k] = (Select_Line == SEL_W'(k));
    end
    in_range = |sel_hit;
    // Head-of-line: only the selected port's slot decides readiness.
    In_Ready = !in_range || !(|(sel_hit & Out_Valid)) || (|(sel_hit & Out_Ready));
    accept   = In_Valid && In_Ready;
    load     = sel_hit & {NUM_OUTPUTS{accept}};
    drop_d   = accept && !in_range;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      drop_q <= 1'b0;
    end else begin
      drop_q <= drop_d;
    end
  end

  assign Drop_Pulse = drop_q;

  for (genvar k = 0; k < NUM_OUTPUTS; k++) begin : g_slot
    stream_demux_slot #(
      .DATA_W(DATA_W)
    ) u_slot (
      .clk       (Clk),
      .rst_n     (Reset_n),
      .load      (load[k]),
      .load_data (In_Data),
      .out_ready (Out_Ready[k]),
      .out_valid (Out_Valid[k]),
      .out_data  (Out_Data[k*DATA_W +: DATA_W])
`ifdef STREAM_DEMUX_STATS_EN
      ,
      .out_count (Out_Count[k*COUNT_W +: COUNT_W])
`endif
    );
  end

endmodule

// File: tb/tb_stream_demux.sv
// tb/tb_stream_demux.sv - scoreboard testbench for stream_demux
module tb_stream_demux;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [7:0]  in_data;
  logic [1:0]  sel;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic        drop;

  logic [7:0]  in_data2;
  logic [1:0]  sel2;
  logic        in_valid2;
  logic        in_ready2;
  logic [23:0] out_data2;
  logic [2:0]  out_valid2;
  logic [2:0]  out_ready2;
  logic        drop2;

`ifdef STREAM_DEMUX_STATS_EN
  logic [63:0] out_count;
  logic [47:0] out_count2;
`endif

  stream_demux #(.DATA_W(8), .NUM_OUTPUTS(4), .SEL_W(2)) dut (
    .Clk(clk), .Reset_n(rst_n), .In_Data(in_data), .Select_Line(sel),
    .In_Valid(in_valid), .In_Ready(in_ready), .Out_Data(out_data),
    .Out_Valid(out_valid), .Out_Ready(out_ready), .Drop_Pulse(drop)
`ifdef STREAM_DEMUX_STATS_EN
    , .Out_Count(out_count)
`endif
  );

  stream_demux #(.DATA_W(8), .NUM_OUTPUTS(3), .SEL_W(2)) dut3 (
    .Clk(clk), .Reset_n(rst_n), .In_Data(in_data2), .Select_Line(sel2),
    .In_Valid(in_valid2), .In_Ready(in_ready2), .Out_Data(out_data2),
    .Out_Valid(out_valid2), .Out_Ready(out_ready2), .Drop_Pulse(drop2)
`ifdef STREAM_DEMUX_STATS_EN
    , .Out_Count(out_count2)
`endif
  );

  int total = 0;
  int bad = 0;
  int stalls = 0;
  logic [7:0] exp_q[4][$];
  logic [7:0] mon_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every output transfer pops the port's expected queue.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 4; k++) begin
        if (out_valid[k] && out_ready[k]) begin
          if (exp_q[k].size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_beat port%0d: got %0h expected none", k, out_data[k*8 +: 8]);
          end else begin
            mon_e = exp_q[k].pop_front();
            check($sformatf("port%0d_data", k), 64'(out_data[k*8 +: 8]), 64'(mon_e));
          end
        end
      end
    end
  end

  task automatic send(input logic [1:0] s, input logic [7:0] d);
    int n;
    n = 0;
    in_valid = 1'b1;
    sel      = s;
    in_data  = d;
    @(negedge clk);
    while (!in_ready && n < 40) begin
      n++;
      stalls++;
      @(negedge clk);
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout: in_ready got 0 required 1");
    end else begin
      exp_q[s].push_back(d);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: time limit reached required finish");
    $fatal(1, "watchdog");
  end

  logic [1:0] a_sel [4];
  logic [7:0] a_dat [4];
  logic [3:0] a_vld [4];

  initial begin
    int n;
    a_sel = '{2'd0, 2'd1, 2'd3, 2'd2};
    a_dat = '{8'hA5, 8'h3C, 8'hFF, 8'h81};
    a_vld = '{4'b0001, 4'b0010, 4'b1000, 4'b0100};

    rst_n = 1'b0; in_data = '0; sel = '0; in_valid = 1'b0; out_ready = 4'hF;
    in_data2 = '0; sel2 = '0; in_valid2 = 1'b0; out_ready2 = 3'b111;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'h0);
    check("rst_out_data", 64'(out_data), 64'h0);
    check("rst_drop", 64'(drop), 64'h0);
    check("rst_in_ready", 64'(in_ready), 64'h1);
`ifdef STREAM_DEMUX_STATS_EN
    check("rst_count", out_count, 64'h0);
`endif

    // Back-to-back beats to four ports, consumers always ready.
    @(posedge clk); #1;
    stalls = 0;
    for (int i = 0; i < 4; i++) begin
      send(a_sel[i], a_dat[i]);
      check($sformatf("seq_valid%0d", i), 64'(out_valid), 64'(a_vld[i]));
    end
    check("seq_stalls", 64'(stalls), 64'h0);
    @(posedge clk); #1;
    check("seq_idle_valid", 64'(out_valid), 64'h0);

    // Head-of-line blocking on port 1.
    out_ready = 4'b1101;
    send(2'd1, 8'h11);
    in_valid = 1'b1; sel = 2'd1; in_data = 8'h22;
    @(negedge clk);
    check("hol_ready_a", 64'(in_ready), 64'h0);
    check("hol_hold_a", 64'(out_data[15:8]), 64'h11);
    @(posedge clk); #1;
    @(negedge clk);
    check("hol_ready_b", 64'(in_ready), 64'h0);
    check("hol_hold_b", 64'(out_data[15:8]), 64'h11);
    check("hol_port0_empty", 64'(out_valid[0]), 64'h0);
    @(posedge clk); #1;
    out_ready = 4'hF;
    @(negedge clk);
    check("hol_release_ready", 64'(in_ready), 64'h1);
    exp_q[1].push_back(8'h22);
    @(posedge clk); #1;
    check("hol_no_bubble", 64'(out_valid[1]), 64'h1);
    check("hol_new_data", 64'(out_data[15:8]), 64'h22);
    send(2'd0, 8'h33);
    check("hol_port0_valid", 64'(out_valid), 64'b0001);

    // Simultaneous drain and load on port 2.
    out_ready = 4'b1011;
    send(2'd2, 8'h50);
    out_ready = 4'hF;
    stalls = 0;
    send(2'd2, 8'h9D);
    check("dl_stalls", 64'(stalls), 64'h0);
    check("dl_valid", 64'(out_valid[2]), 64'h1);
    check("dl_data", 64'(out_data[23:16]), 64'h9D);
    repeat (2) @(posedge clk);
    #1;
    check("dl_idle_valid", 64'(out_valid), 64'h0);

    // Out-of-range select on the three-port instance.
    in_valid2 = 1'b1; sel2 = 2'd3; in_data2 = 8'h7E;
    @(negedge clk);
    check("drop_in_ready", 64'(in_ready2), 64'h1);
    check("drop_pre", 64'(drop2), 64'h0);
    @(posedge clk); #1;
    in_valid2 = 1'b0;
    @(negedge clk);
    check("drop_pulse", 64'(drop2), 64'h1);
    check("drop_no_valid", 64'(out_valid2), 64'h0);
    @(posedge clk); #1;
    @(negedge clk);
    check("drop_pulse_end", 64'(drop2), 64'h0);
    check("drop_main_quiet", 64'(drop), 64'h0);

    // Reset mid-stream with ports 0 and 2 holding beats.
    @(posedge clk); #1;
    out_ready = 4'b1010;
    send(2'd0, 8'h12);
    send(2'd2, 8'h34);
    check("mid_pre_valid", 64'(out_valid), 64'b0101);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'h0);
    check("mid_rst_data", 64'(out_data), 64'h0);
    for (int k = 0; k < 4; k++) exp_q[k].delete();
    @(posedge clk); #1 rst_n = 1'b1;
    out_ready = 4'hF;
    @(negedge clk);
    check("mid_after_valid", 64'(out_valid), 64'h0);
    check("mid_after_data", 64'(out_data), 64'h0);
`ifdef STREAM_DEMUX_STATS_EN
    check("mid_after_count", out_count, 64'h0);

    // Saturation: 65540 transfers on port 0.
    @(posedge clk); #1;
    in_valid = 1'b1; sel = 2'd0;
    for (int i = 0; i < 65540; i++) begin
      in_data = 8'(i);
      @(negedge clk);
      if (!in_ready) begin
        total++; bad++;
        $display("FAIL sat_ready: got 0 required 1");
      end else begin
        exp_q[0].push_back(8'(i));
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("sat_count0", 64'(out_count[15:0]), 64'hFFFF);
    check("sat_count_others", 64'(out_count[63:16]), 64'h0);
`endif

    n = 0;
    while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size()) != 0 && n < 20) begin
      n++;
      @(posedge clk);
    end
    for (int k = 0; k < 4; k++) begin
      check($sformatf("drain_port%0d_left", k), 64'(exp_q[k].size()), 64'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stream_demux.md
# stream_demux

Registered 1-to-N stream demultiplexer with valid/ready handshake. It is the inverse of the codebase's 2:1 selector. Each input beat carries its own select value. The beat is routed to exactly one of NUM_OUTPUTS output ports through a single-entry holding register per port. The block sits between a single producer and N independent consumers, and gives full throughput when the selected consumer keeps up.

## Interface
- DATA_W, default 8: payload width in bits.
- NUM_OUTPUTS, default 4: number of output ports; legal range 2..16.
- SEL_W, default 2: select width; must satisfy 2**SEL_W >= NUM_OUTPUTS.

Ports:
- Clk  input  1  rising-edge clock.
- Reset_n  input  1  asynchronous active-low reset.
- In_Data  input  DATA_W  input payload.
- Select_Line  input  SEL_W  destination index, sampled with In_Data.
- In_Valid  input  1  input beat present.
- In_Ready  output  1  block accepts beat this cycle.
- Out_Data  output  NUM_OUTPUTS*DATA_W  port k payload at bits [k*DATA_W +: DATA_W].
- Out_Valid  output  NUM_OUTPUTS  per-port beat present.
- Out_Ready  input  NUM_OUTPUTS  per-port consumer ready.
- Drop_Pulse  output  1  one-cycle pulse when a beat with an out-of-range select is discarded.
- Out_Count  output  NUM_OUTPUTS*16  per-port transfer counters; present only with STREAM_DEMUX_STATS_EN.

## Operation
- Reset (Reset_n low, asynchronous): all Out_Valid=0, Out_Data=0, Drop_Pulse=0, Out_Count=0. In_Ready is combinational and reads 1 for any in-range select while every slot is empty.
- Transfer rules:
  - An input transfer occurs when In_Valid && In_Ready.
  - An output transfer on port k occurs when Out_Valid[k] && Out_Ready[k].
- Each port has a slot in one of two states, EMPTY or FULL.
  - EMPTY -> FULL: input transfer with Select_Line==k.
  - FULL -> EMPTY: output transfer on k with no simultaneous load to k.
  - FULL -> FULL: output transfer on k and load to k in the same cycle. The slot takes the new data, so there is no bubble.
- In_Ready = (Select_Line >= NUM_OUTPUTS) || !Out_Valid[sel] || Out_Ready[sel]. It depends only on the selected port.
- Head-of-line blocking is intended: a stalled selected port holds In_Ready low even when other ports are empty.
- Out-of-range select: the beat is accepted (In_Ready=1), no slot changes, and Drop_Pulse=1 on the following cycle.
- At most one slot loads per cycle. Any number of slots may drain in the same cycle.
- While Out_Valid[k] && !Out_Ready[k], Out_Data for port k holds stable.
- Reset asserted mid-operation discards all held beats immediately, with no drain.

## Timing
- Latency: a beat accepted at edge n is visible on Out_Valid[k]/Out_Data at edge n (registered output), i.e. the consumer can take it at edge n+1.
- Throughput: 1 beat/cycle when the selected consumer holds Out_Ready high.
- In_Ready has a combinational path from Select_Line and Out_Ready. There is no combinational path from In_Valid to any output.
- Drop_Pulse is registered and is exactly one cycle wide for each dropped beat. Back-to-back drops hold it high.

## Configuration
- STREAM_DEMUX_STATS_EN:
  - When defined: each port has a 16-bit counter that increments on every output transfer on that port and saturates at 16'hFFFF. Counters reset to 0 and are exposed on Out_Count.
  - When undefined: counters and the Out_Count port are absent, and all other behaviour is identical.

## Structure
- Package stream_demux_pkg holds:
  - slot-state encoding (SLOT_EMPTY=1'b0, SLOT_FULL=1'b1);
  - COUNT_W=16 and COUNT_MAX.
- Sub-module stream_demux_slot: single-entry register with load/drain handshake, instantiated NUM_OUTPUTS times in a generate loop. With the macro defined, the optional saturating counter lives inside the slot.

## Test plan
- Reset mid-stream, with ports 0 and 2 FULL -> next cycle Out_Valid=4'b0000, Out_Data=0, Out_Count=0.
- Sequence A5 (sel 0), 3C (sel 1), FF (sel 3), 81 (sel 2) on consecutive cycles, all Out_Ready=1 -> each beat appears one cycle later on the matching port; Out_Valid pulses 0001, 0010, 1000, 0100; no stall.
- Hold Out_Ready[1]=0, send 11 then 22 to sel 1, then 33 to sel 0:
  - In_Ready drops on the second beat and blocks 33 (head-of-line), with Out_Data port 1 = 11 stable;
  - raise Out_Ready[1] -> 22 follows with no bubble, then 33 reaches port 0.
- NUM_OUTPUTS=3 with SEL_W=2, beat 7E with sel 3 -> In_Ready=1, no Out_Valid change, Drop_Pulse=1 for exactly one cycle.
- Simultaneous drain/load on port 2 (FULL, Out_Ready[2]=1, new beat 9D to sel 2) -> Out_Valid[2] stays 1 and Out_Data port 2 = 9D next cycle.
- STREAM_DEMUX_STATS_EN defined, 65540 transfers on port 0 -> Out_Count port 0 = 16'hFFFF and other counters are 0.
